traffic_phase_timer: RTL and testbench

Timing and sensor-conditioning companion to the two-road traffic light FSM. It generates the timer_a/timer_b phase-expiry inputs from a prescaled tick and runtime-configurable green durations, and it synchronises and debounces the raw road sensors into clean Sa/Sb. It sits between the board I/O and the light controller and is driven by the controller's reset_timer, Ga and Gb outputs.

---
 rtl/traffic_phase_timer.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// Purpose : phase timer (prescaled tick, shadowed green durations) and sensor debounce for the two-road light FSM.
// Latency : timer_x rises green_x*CLK_PER_TICK cycles after reset_timer rises; sensor edges reach Sa/Sb DEB_CYCLES+2 cycles later.
// Backpressure: none; config writes are always accepted into a shadow and applied when the timer is idle.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   reset_timer, Ga, Gb : controller phase-active and green indications
//   Sa_raw, Sb_raw      : asynchronous road sensors
//   cfg_we/sel/data     : green-duration write (sel 0 = road A, 1 = road B), in ticks
//   Sa, Sb              : debounced sensors
//   timer_a, timer_b    : green duration elapsed for the road currently green
//   tick                : one-cycle prescaler pulse
module traffic_phase_timer #(
    parameter int CLK_PER_TICK = 100,
    parameter int CNT_W        = 8,
    parameter int GREEN_A_DEF  = 30,
    parameter int GREEN_B_DEF  = 20,
    parameter int DEB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_timer,
    input  logic             Ga,
    input  logic             Gb,
    input  logic             Sa_raw,
    input  logic             Sb_raw,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             Sa,
    output logic             Sb,
    output logic             timer_a,
    output logic             timer_b,
    output logic             tick
);

    localparam int PRE_W = (CLK_PER_TICK < 2) ? 1 : $clog2(CLK_PER_TICK);
    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] GA_DEF   = CNT_W'(GREEN_A_DEF);
    localparam logic [CNT_W-1:0] GB_DEF   = CNT_W'(GREEN_B_DEF);

    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] green_a, green_b;
    logic [CNT_W-1:0] shadow_a, shadow_b;
    logic             pend_a, pend_b;
    logic             tick_int;

    // Bit 0 = road A, bit 1 = road B; both sensors share identical conditioning.
    logic [1:0]       sens_raw;
    logic [1:0]       sync1, sync2, deb_q;
    logic [DEB_W-1:0] deb_cnt [2];

    assign tick_int = reset_timer & (pre_cnt == PRE_LAST);
    assign sens_raw = {Sb_raw, Sa_raw};

    // ------------------------------------------------------------------
    // Prescaler and saturating tick counter; both idle at 0 between phases.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (!reset_timer) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pre_cnt <= tick_int ? '0 : pre_cnt + PRE_W'(1);
            if (tick_int && tick_cnt != CNT_MAX)
                tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Duration config. Writes land in a shadow; the active register only
    // changes while the timer is idle, so a running phase is never
    // retimed. A write coinciding with a transfer stays pending because
    // the write's flag update is ordered after the transfer's clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            green_a  <= GA_DEF;
            green_b  <= GB_DEF;
            shadow_a <= GA_DEF;
            shadow_b <= GB_DEF;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
        end else begin
            if (!reset_timer && pend_a) begin
                green_a <= shadow_a;
                pend_a  <= 1'b0;
            end
            if (!reset_timer && pend_b) begin
                green_b <= shadow_b;
                pend_b  <= 1'b0;
            end
            if (cfg_we && !cfg_sel) begin
                shadow_a <= cfg_data;
                pend_a   <= 1'b1;
            end
            if (cfg_we && cfg_sel) begin
                shadow_b <= cfg_data;
                pend_b   <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sensor conditioning: two-flop synchroniser, then the output only
    // follows after DEB_CYCLES consecutive disagreeing samples.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            deb_q      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= sens_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_q[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Outputs are forced low while reset is held, whatever stale state
    // the counters carry into the reset cycle.
    assign tick    = tick_int & ~reset;
    assign timer_a = ~reset & reset_timer & Ga & (tick_cnt >= green_a);
    assign timer_b = ~reset & reset_timer & Gb & (tick_cnt >= green_b);
    assign Sa      = deb_q[0];
    assign Sb      = deb_q[1];

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with CLK_PER_TICK=4 and default durations.
// Cycle 0 of a phase is the first cycle in which reset_timer is 1.
module tb_traffic_phase_timer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset, reset_timer, Ga, Gb, Sa_raw, Sb_raw;
    logic             cfg_we, cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             Sa, Sb, timer_a, timer_b, tick;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    traffic_phase_timer #(
        .CLK_PER_TICK(4),
        .CNT_W       (CNT_W),
        .GREEN_A_DEF (30),
        .GREEN_B_DEF (20),
        .DEB_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_timer(reset_timer),
        .Ga         (Ga),
        .Gb         (Gb),
        .Sa_raw     (Sa_raw),
        .Sb_raw     (Sb_raw),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .Sa         (Sa),
        .Sb         (Sb),
        .timer_a    (timer_a),
        .timer_b    (timer_b),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Starting in cycle 'start' of a phase, find the first cycle with the
    // selected timer high; -1 if it never rises by 'limit'.
    task automatic rise(input int start, input int limit, input logic sel_b, output int n);
        n = -1;
        for (int c = start; c <= limit; c++) begin
            #1;
            if ((sel_b ? timer_b : timer_a) === 1'b1) begin
                n = c;
                break;
            end
            cyc();
        end
    endtask

    // Cycles until the selected debounced sensor shows 'val'; -1 if not within 20.
    task automatic sens_delay(input logic sel_b, input logic val, output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            #1;
            if ((sel_b ? Sb : Sa) === val) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int   n;
        logic ok;

        reset = 1'b1; reset_timer = 1'b1; Ga = 1'b1; Gb = 1'b1;
        Sa_raw = 1'b0; Sb_raw = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;

        // Reset state, with the controller inputs active to show gating.
        repeat (3) cyc();
        #1;
        chk("rst_tick", tick, 0);
        chk("rst_timer_a", timer_a, 0);
        chk("rst_timer_b", timer_b, 0);
        chk("rst_Sa", Sa, 0);
        chk("rst_Sb", Sb, 0);

        cyc(); reset = 1'b0; reset_timer = 1'b0; Ga = 1'b0; Gb = 1'b0;
        #1;
        chk("idle_tick", tick, 0);

        // Road-A phase with default 30 ticks: tick every 4th cycle, expiry at 120.
        cyc(); reset_timer = 1'b1; Ga = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("tick_c%0d", c), tick, (c % 4 == 3) ? 1 : 0);
            cyc();
        end
        rise(12, 200, 1'b0, n);
        chk("a_default_expiry", n, 120);
        chk("b_idle_in_a", timer_b, 0);
        repeat (4) cyc();
        #1;
        chk("a_holds", timer_a, 1);

        cyc(); reset_timer = 1'b0; Ga = 1'b0;
        #1;
        chk("a_drop_timer", timer_a, 0);
        chk("a_drop_tick", tick, 0);

        // Road-B phase interrupted for one cycle after 100 cycles: restarts.
        cyc(); reset_timer = 1'b1; Gb = 1'b1;
        repeat (100) cyc();
        reset_timer = 1'b0;
        #1;
        chk("b_drop_timer", timer_b, 0);
        cyc(); reset_timer = 1'b1;
        rise(0, 200, 1'b1, n);
        chk("b_restart_expiry", n, 80);

        // Config write mid-phase does not retime the running phase.
        cyc(); reset_timer = 1'b0; Gb = 1'b0;
        cyc(); reset_timer = 1'b1; Ga = 1'b1;
        repeat (20) cyc();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd3;
        #1;
        chk("a_c20_low", timer_a, 0);
        cyc(); cfg_we = 1'b0;
        rise(21, 200, 1'b0, n);
        chk("a_unaffected_expiry", n, 120);

        cyc(); reset_timer = 1'b0; Ga = 1'b0;
        cyc(); reset_timer = 1'b1; Ga = 1'b1;
        rise(0, 200, 1'b0, n);
        chk("a_green3_expiry", n, 12);

        // Pending A=6, back-to-back B writes 9 then 0 (last wins).
        cyc(); cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd6;
        cyc(); cfg_sel = 1'b1; cfg_data = 8'd9;
        cyc(); cfg_data = 8'd0;
        cyc(); cfg_we = 1'b0;
        #1;
        chk("a_phase_not_retimed", timer_a, 1);

        // Write during the transfer cycle: 6 is applied, 2 stays pending.
        cyc(); reset_timer = 1'b0; Ga = 1'b0; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd2;
        cyc(); cfg_we = 1'b0; reset_timer = 1'b1; Ga = 1'b1;
        rise(0, 200, 1'b0, n);
        chk("a_green6_expiry", n, 24);
        cyc(); reset_timer = 1'b0; Ga = 1'b0;
        cyc(); reset_timer = 1'b1; Ga = 1'b1;
        rise(0, 200, 1'b0, n);
        chk("a_green2_expiry", n, 8);

        // green_b = 0 expires in cycle 0.
        cyc(); reset_timer = 1'b0; Ga = 1'b0;
        cyc(); reset_timer = 1'b1; Gb = 1'b1;
        #1;
        chk("b_zero_expiry", timer_b, 1);
        chk("a_not_green", timer_a, 0);

        // Debounce: clean edges take 6 cycles, 3-cycle glitch rejected.
        cyc(); reset_timer = 1'b0; Gb = 1'b0; Sb_raw = 1'b1;
        sens_delay(1'b1, 1'b1, n);
        chk("sb_rise_delay", n, 6);
        Sb_raw = 1'b0;
        sens_delay(1'b1, 1'b0, n);
        chk("sb_fall_delay", n, 6);
        Sb_raw = 1'b1;
        repeat (3) cyc();
        Sb_raw = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            cyc(); #1;
            if (Sb !== 1'b0) ok = 1'b0;
        end
        chk("sb_glitch_rejected", ok, 1);

        // A 4-cycle pulse on Sa is just long enough to be accepted.
        Sa_raw = 1'b1;
        repeat (4) cyc();
        Sa_raw = 1'b0;
        #1;
        chk("sa_pulse_k4", Sa, 0);
        cyc(); #1;
        chk("sa_pulse_k5", Sa, 0);
        cyc(); #1;
        chk("sa_pulse_k6", Sa, 1);
        sens_delay(1'b0, 1'b0, n);
        chk("sa_pulse_release", n, 4);

        // green_a = 255 with an 8-bit counter: expires, and never wraps.
        cyc(); cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd255;
        cyc(); cfg_we = 1'b0;
        cyc(); reset_timer = 1'b1; Ga = 1'b1;
        rise(0, 1100, 1'b0, n);
        chk("a_green255_expiry", n, 1020);
        ok = 1'b1;
        repeat (200) begin
            cyc(); #1;
            if (timer_a !== 1'b1) ok = 1'b0;
        end
        chk("a_saturate_no_wrap", ok, 1);

        // Reset mid-phase with Sa high and a pending config write.
        Sa_raw = 1'b1;
        sens_delay(1'b0, 1'b1, n);
        chk("sa_rise_delay", n, 6);
        cyc(); cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd1;
        cyc(); cfg_we = 1'b0; reset = 1'b1;
        #1;
        chk("midrst_timer_a", timer_a, 0);
        chk("midrst_tick", tick, 0);
        cyc(); reset = 1'b0; reset_timer = 1'b0;
        #1;
        chk("postrst_Sa", Sa, 0);
        chk("postrst_timer_a", timer_a, 0);
        cyc(); reset_timer = 1'b1;
        rise(0, 200, 1'b0, n);
        chk("postrst_default_expiry", n, 120);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
